bcd_ex3_word_sequencer: RTL

Sequencer that shares one 4-bit BCD-to-excess-3 converter across all digits of a packed multi-digit BCD word. It accepts a word on a valid/ready input and presents one digit per cycle to the external converter, LSB digit first. It collects the converted nibbles into a packed excess-3 word, flags non-BCD digits (>9), and returns the result on a valid/ready output. It sits between a BCD-producing source (counter or display path) and the excess-3 consumer.

---
 rtl/bcd_ex3_word_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/bcd_ex3_word_sequencer.sv
// Feeds one shared BCD-to-excess-3 converter with each digit of a packed BCD word, LSB first,
// and gathers the converted nibbles into an excess-3 word. Non-BCD digits are flagged.
module bcd_ex3_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       wr,
  input  logic       bad,
  input  logic [3:0] ex3,
  output logic [3:0] q
);
  // 4'h0 is never a legal excess-3 code, so it doubles as the per-nibble invalid marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= 4'h0;
    else if (clr) q <= 4'h0;
    else if (wr)  q <= bad ? 4'h0 : ex3;
  end
endmodule

module bcd_ex3_word_sequencer #(
  parameter  int DIGITS = 4,
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic [3:0]            conv_bcd,
  input  logic [3:0]            conv_ex3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic                  out_err,
  output logic [IDX_W-1:0]      out_err_idx,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q;
  logic [DIGITS-1:0][3:0]  word_q;
  logic [DIGITS-1:0][3:0]  res;
  logic                    err_q;
  logic [IDX_W-1:0]        err_idx_q;
  logic [3:0]              cur;
  logic                    bad, last, accept, in_conv;

  assign cur     = word_q[idx_q];
  assign bad     = (cur > 4'd9);
  assign last    = (idx_q == IDX_W'(DIGITS - 1));
  assign in_conv = (state_q == CONV);
  assign accept  = in_valid && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // every output decodes from registers only: no in_valid->in_ready or out_ready->out_valid path
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    conv_bcd  = 4'h0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = CONV;
      end
      CONV: begin
        conv_bcd = cur;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q    <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else if (accept) begin
      word_q    <= in_data;
      idx_q     <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else if (in_conv) begin
      if (bad) begin
        err_q <= 1'b1;
        if (!err_q) err_idx_q <= idx_q;  // lowest invalid index wins
      end
      if (!last) idx_q <= idx_q + 1'b1;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_lane
    bcd_ex3_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .wr    (in_conv && (idx_q == IDX_W'(k))),
      .bad   (bad),
      .ex3   (conv_ex3),
      .q     (res[k])
    );
  end

  assign out_data    = res;
  assign out_err     = err_q;
  assign out_err_idx = err_idx_q;
endmodule
